sdram_req_queue: RTL
====================

SDRAM_REQ_QUEUE -- requirements
Module: sdram_req_queue

Interface
REQ-001 Parameter DEPTH, 4, request FIFO entries; power of two, minimum 2.
REQ-002 Parameter HOLD_CYC, 3, cycles mem_rd/mem_wr stay asserted per issued request; minimum 2.
REQ-003 Parameter RD_LAT, 3, cycles from issue start to mem_rdata capture; 1 <= RD_LAT <= HOLD_CYC.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset_n  input  1  reset; synchronous, active-low.
REQ-006 req_valid  input  1  user request present.
REQ-007 req_ready  output  1  queue can accept a request.
REQ-008 req_we  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  25  bits {row[24:12], bank[11:10], col[9:0]}.
REQ-010 req_wdata  input  16  write data.
REQ-011 rsp_valid  output  1  one-cycle pulse; read data valid.
REQ-012 rsp_data  output  16  read data.
REQ-013 mem_ready  input  1  controller idle and able to take a command.
REQ-014 mem_rd  output  1  read request to controller.
REQ-015 mem_wr  output  1  write request to controller.
REQ-016 mem_addr  output  25  request address to controller.
REQ-017 mem_wdata  output  16  write data to controller.
REQ-018 mem_rdata  input  16  read data from controller.
REQ-019 busy  output  1  FSM not in IDLE, or FIFO non-empty.

Function
REQ-020 A request is accepted on a cycle with req_valid=1 and req_ready=1; {req_we, req_addr, req_wdata} is pushed, 42 bits.
REQ-021 req_ready = FIFO not full, registered-count based; a pop in the same cycle does not raise req_ready while full.
REQ-022 FIFO count is $clog2(DEPTH)+1 bits; read/write pointers wrap modulo DEPTH; push and pop in the same cycle leave count unchanged.
REQ-023 FSM states: IDLE, ISSUE, RESP.
REQ-024 IDLE: if FIFO non-empty and mem_ready=1, pop the head into issue registers and go to ISSUE; otherwise stay in IDLE.
REQ-025 ISSUE: mem_rd = ~we, mem_wr = we; mem_addr and mem_wdata held stable from issue registers; hold counter runs 0..HOLD_CYC-1.
REQ-026 ISSUE for a read: mem_rdata is captured into rsp_data on the cycle the hold counter equals RD_LAT-1.
REQ-027 ISSUE exits on hold counter = HOLD_CYC-1: reads go to RESP, writes go to IDLE.
REQ-028 RESP lasts exactly one cycle with rsp_valid=1, then goes to IDLE.
REQ-029 mem_rd and mem_wr are never asserted together, and both are 0 outside ISSUE.
REQ-030 Requests issue strictly in acceptance order; no reordering or merging.
REQ-031 mem_ready falling during ISSUE is ignored; mem_ready is sampled only in IDLE.
REQ-032 Writes produce no response.
REQ-033 Back-to-back issue: minimum spacing between issue starts is HOLD_CYC+1 cycles for writes and HOLD_CYC+2 for reads.

Reset
REQ-034 While reset_n=0 at a clock edge: FSM to IDLE, FIFO emptied, pointers and count 0, hold counter 0.
REQ-035 Reset outputs: req_ready=1, rsp_valid=0, rsp_data=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, busy=0.
REQ-036 Reset mid-ISSUE drops the in-flight request and all queued requests; no rsp_valid follows.

Structure
REQ-037 Package sdram_pkg holds: the SDRAM command encodings (NOP/ACTIVE/READ/WRITE/PRECHARGE/REFRESH/LOAD), the address field bit positions, and the queue FSM state enum.
REQ-038 The FIFO is sub-module sdram_req_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty, count); the FSM lives in sdram_req_queue.

Verification
REQ-039 Single write: addr 0x0123456, wdata 0xBEEF, mem_ready=1 -> mem_wr high for exactly 3 cycles with mem_addr=0x0123456 and mem_wdata=0xBEEF; no rsp_valid.
REQ-040 Single read: addr 0x1000005, bench drives mem_rdata=0xA5A5 at hold count 2 -> rsp_valid pulses once with rsp_data=0xA5A5, 4 cycles after issue start.
REQ-041 Fill: 5 consecutive requests with mem_ready=0 -> first 4 accepted, req_ready=0 on the 5th; release mem_ready -> issued in order, req_ready returns to 1 after the first pop.
REQ-042 Mixed W,R,W,R to the same address with mem_ready=1 -> issue order preserved, exactly 2 rsp_valid pulses, mem_rd and mem_wr never both high.
REQ-043 reset_n=0 during ISSUE of the 2nd of 3 queued reads -> next cycle all outputs at reset values, no rsp_valid afterwards, busy=0.
REQ-044 mem_ready toggled low mid-ISSUE -> issue completes unchanged; the next request waits in IDLE until mem_ready=1.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM request queue: command encodings,
// address field layout and the issue FSM state type.
package sdram_pkg;

    localparam int unsigned ADDR_W = 25;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned REQ_W  = 1 + ADDR_W + DATA_W;

    // Address layout: {row, bank, col}
    localparam int unsigned ROW_MSB  = 24;
    localparam int unsigned ROW_LSB  = 12;
    localparam int unsigned BANK_MSB = 11;
    localparam int unsigned BANK_LSB = 10;
    localparam int unsigned COL_MSB  = 9;
    localparam int unsigned COL_LSB  = 0;

    // {cs_n, ras_n, cas_n, we_n}
    typedef enum logic [3:0] {
        CmdLoad      = 4'b0000,
        CmdRefresh   = 4'b0001,
        CmdPrecharge = 4'b0010,
        CmdActive    = 4'b0011,
        CmdWrite     = 4'b0100,
        CmdRead      = 4'b0101,
        CmdNop       = 4'b0111
    } sdram_cmd_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StResp  = 2'd2
    } queue_state_e;

    function automatic logic [REQ_W-1:0] pack_req(input logic              we,
                                                  input logic [ADDR_W-1:0] addr,
                                                  input logic [DATA_W-1:0] wdata);
        return {we, addr, wdata};
    endfunction

endpackage

// File: rtl/sdram_req_fifo.sv
// Request FIFO: DEPTH entries of WIDTH bits, registered count, head visible on dout.
module sdram_req_fifo #(
    parameter int unsigned WIDTH = 42,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CNT_DEPTH);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so pointer overflow is the modulo wrap.
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/sdram_req_queue.sv
// Queues user read/write requests and issues them one at a time to an SDRAM
// controller, holding each command for HOLD_CYC cycles and returning read data.
module sdram_req_queue
    import sdram_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned HOLD_CYC = 3,
    parameter int unsigned RD_LAT   = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              mem_ready,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned HOLD_W = $clog2(HOLD_CYC);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
    localparam logic [HOLD_W-1:0] RD_CAP    = HOLD_W'(RD_LAT - 1);

    queue_state_e      state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              iss_we_q, iss_we_d;
    logic [ADDR_W-1:0] iss_addr_q, iss_addr_d;
    logic [DATA_W-1:0] iss_wdata_q, iss_wdata_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [REQ_W-1:0]  fifo_dout;
    logic [CNT_W-1:0]  fifo_count;
    logic              head_we;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;

    assign req_ready = !fifo_full;
    assign fifo_push = req_valid && req_ready;
    assign {head_we, head_addr, head_wdata} = fifo_dout;

    sdram_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .din     (pack_req(req_we, req_addr, req_wdata)),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        iss_we_d    = iss_we_q;
        iss_addr_d  = iss_addr_q;
        iss_wdata_d = iss_wdata_q;
        rsp_data_d  = rsp_data_q;
        fifo_pop    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty && mem_ready) begin
                    fifo_pop    = 1'b1;
                    iss_we_d    = head_we;
                    iss_addr_d  = head_addr;
                    iss_wdata_d = head_wdata;
                    hold_d      = '0;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                if (!iss_we_q && (hold_q == RD_CAP)) rsp_data_d = mem_rdata;
                // mem_ready is deliberately ignored here; a started command always completes.
                if (hold_q == HOLD_LAST) begin
                    hold_d  = '0;
                    state_d = iss_we_q ? StIdle : StResp;
                end else begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            hold_q      <= '0;
            iss_we_q    <= 1'b0;
            iss_addr_q  <= '0;
            iss_wdata_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            iss_we_q    <= iss_we_d;
            iss_addr_q  <= iss_addr_d;
            iss_wdata_q <= iss_wdata_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign mem_rd    = (state_q == StIssue) && !iss_we_q;
    assign mem_wr    = (state_q == StIssue) && iss_we_q;
    assign mem_addr  = iss_addr_q;
    assign mem_wdata = iss_wdata_q;
    assign rsp_valid = (state_q == StResp);
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != StIdle) || (fifo_count != '0);

endmodule
